hamiltonian_scheduler: RTL and testbench
========================================

# hamiltonian_scheduler

Shares one `hamiltonian_generator` between `N_REQ` molecular-structure requesters. Round-robin arbitration picks one pending request, drives its 256-bit structure onto the generator, waits for `hamiltonian_ready` with a bounded timeout, then drains the generator by driving zero until ready drops. It reports a per-job completion status back to the winning requester and sits directly upstream of the generator.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..16.
- `STRUCT_W`, default 256: structure width; must match the generator.
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in WAIT or in DRAIN.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `structure_in`  in  N_REQ*STRUCT_W  requester i occupies slice [i*STRUCT_W +: STRUCT_W].
- `ack`  out  N_REQ  one-hot, one-cycle pulse when a request is accepted.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_id`  out  $clog2(N_REQ)  requester index of the completed job.
- `done_status`  out  2  00 OK, 01 TIMEOUT, 10 ZERO_REJECT.
- `gen_structure`  out  STRUCT_W  registered; connects to the generator's `molecular_structure`.
- `gen_ready`  in  1  the generator's `hamiltonian_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, DRAIN.
- IDLE arbitration:
  - Arbitration occurs only when `gen_ready`==0. A stale high ready stalls arbitration.
  - The winner is the first asserted `req` at or after `rr_ptr`, searching upward with wrap.
  - `rr_ptr` becomes winner+1 mod N_REQ on every grant, including a reject.
- Grant with non-zero structure:
  - `gen_structure` latches the slice, `ack[winner]` pulses, and the block goes to WAIT with the counter cleared.
- Grant with all-zero structure:
  - `ack` and `done_valid` pulse together, with `done_status`=ZERO_REJECT.
  - The block stays in IDLE and `gen_structure` stays 0.
  - The generator would never assert ready for a zero structure, so it is not started.
- WAIT:
  - `gen_ready`=1 moves to DRAIN with the latched status set to OK.
  - Otherwise the counter increments; on reaching TIMEOUT_CYCLES the block moves to DRAIN with status TIMEOUT.
  - On entry to DRAIN, `gen_structure` is set to 0 and the counter clears.
- DRAIN:
  - `gen_ready`=0 produces a `done_valid` pulse with the latched status and returns to IDLE.
  - If the counter reaches TIMEOUT_CYCLES first, `done_valid` pulses with status TIMEOUT (overriding OK) and the block returns to IDLE.
- Requester obligations:
  - Hold `req` and the structure slice until `ack`.
  - Deassert `req` in the cycle after `ack`, or the request is treated as a new one.
  - Withdrawing `req` before `ack` is legal and has no side effects.
- `structure_in` changes after `ack` have no effect; the structure is latched.

## Timing
- Reset (async assert, sync deassert expected):
  - State IDLE, `rr_ptr`=0, counter 0.
  - `gen_structure`=0, `ack`=0, `done_valid`=0, `done_id`=0, `done_status`=00, `busy`=0.
- Nominal job, with `req` sampled in IDLE during cycle t:
  - edge t+1: `ack`, `gen_structure` valid, WAIT.
  - edge t+2: generator raises ready.
  - edge t+3: DRAIN, `gen_structure`=0.
  - edge t+4: ready low.
  - edge t+5: `done_valid` OK, IDLE.
- A new grant can issue at edge t+6, because arbitration runs in the `done_valid` cycle.
- Timeout bound: a job occupies at most 2*TIMEOUT_CYCLES+2 cycles.
- All outputs are registered, so there is no combinational path from inputs to outputs.
- Reset asserted mid-job aborts the job with no `done_valid`; `gen_structure` goes to 0 immediately.
- `gen_ready` asserting in the same cycle the counter hits the limit in WAIT counts as OK (ready wins).

## Structure
- `hamiltonian_sched_pkg`: state enum (IDLE/WAIT/DRAIN), status codes (ST_OK, ST_TIMEOUT, ST_ZERO_REJECT), default STRUCT_W=256.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: `req`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Purely combinational.
  - `rr_ptr` is owned by the scheduler.

## Test plan
- Single request: req[2]=1 with structure 0x…A5 → `ack[2]` at t+1, `gen_structure`=0x…A5 during WAIT, `done_valid` OK with id 2 at t+5, `gen_structure`=0 afterwards.
- Contention: req=4'b1111 held, each requester deasserting after its own `ack`, `rr_ptr`=0 → grant order 0,1,2,3. Then re-assert req[0] and req[3] → grant 0 then 3.
- Zero structure: req[1]=1 with structure 0 → `ack[1]` and `done_valid` ZERO_REJECT in the same cycle, `busy` stays 0, `gen_structure` stays 0.
- Stuck-low generator with TIMEOUT_CYCLES=16 → `done_valid` TIMEOUT 16 cycles after entering WAIT plus the DRAIN exit; the next request is served normally.
- Stuck-high `gen_ready` during DRAIN → `done_valid` TIMEOUT after 16 DRAIN cycles. IDLE must not grant while ready stays 1.
- Reset pulled low during WAIT → all outputs at reset values asynchronously. After release, a pending req is granted from `rr_ptr`=0.

Source files
------------

// File: rtl/hamiltonian_sched_pkg.sv
// Shared types and status codes for the hamiltonian generator scheduler.
package hamiltonian_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam logic [1:0] ST_OK          = 2'b00;
    localparam logic [1:0] ST_TIMEOUT     = 2'b01;
    localparam logic [1:0] ST_ZERO_REJECT = 2'b10;

    localparam int DEF_STRUCT_W = 256;

endpackage

// File: rtl/hamiltonian_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0][IW-1:0] w_cand;

    always_comb begin
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_cand[k] = IW'((int'(ptr) + k) % N);
        end
    end

    // Walk from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/hamiltonian_scheduler.sv
// Round-robin front end that shares one hamiltonian_generator between N_REQ requesters,
// with bounded waits for ready and for the post-job drain.
module hamiltonian_scheduler
    import hamiltonian_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int STRUCT_W       = DEF_STRUCT_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int IW             = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*STRUCT_W-1:0] structure_in,
    output logic [N_REQ-1:0]          ack,
    output logic                      done_valid,
    output logic [IW-1:0]             done_id,
    output logic [1:0]                done_status,
    output logic [STRUCT_W-1:0]       gen_structure,
    input  logic                      gen_ready,
    output logic                      busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    sched_state_e        r_state, w_state_nx;
    logic [IW-1:0]       r_ptr, w_ptr_nx;
    logic [CW-1:0]       r_cnt, w_cnt_nx;
    logic [STRUCT_W-1:0] r_gen, w_gen_nx;
    logic [N_REQ-1:0]    r_ack, w_ack_nx;
    logic                r_dv, w_dv_nx;
    logic [IW-1:0]       r_did, w_did_nx;
    logic [1:0]          r_dst, w_dst_nx;
    logic [IW-1:0]       r_job, w_job_nx;
    logic [1:0]          r_st, w_st_nx;

    logic                w_gnt_valid;
    logic [IW-1:0]       w_gnt_idx;
    logic [STRUCT_W-1:0] w_slice;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_slice = structure_in[int'(w_gnt_idx)*STRUCT_W +: STRUCT_W];

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_gen_nx   = r_gen;
        w_ack_nx   = '0;
        w_dv_nx    = 1'b0;
        w_did_nx   = r_did;
        w_dst_nx   = r_dst;
        w_job_nx   = r_job;
        w_st_nx    = r_st;
        case (r_state)
            IDLE: begin
                // A ready still high from the previous job must clear before a new start.
                if (!gen_ready && w_gnt_valid) begin
                    w_ptr_nx            = (w_gnt_idx == IW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    w_ack_nx[w_gnt_idx] = 1'b1;
                    if (w_slice == '0) begin
                        w_dv_nx  = 1'b1;
                        w_did_nx = w_gnt_idx;
                        w_dst_nx = ST_ZERO_REJECT;
                    end else begin
                        w_gen_nx   = w_slice;
                        w_job_nx   = w_gnt_idx;
                        w_cnt_nx   = '0;
                        w_state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (gen_ready || r_cnt == CNT_LAST) begin
                    w_st_nx    = gen_ready ? ST_OK : ST_TIMEOUT;
                    w_gen_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = DRAIN;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!gen_ready || r_cnt == CNT_LAST) begin
                    w_dv_nx    = 1'b1;
                    w_did_nx   = r_job;
                    w_dst_nx   = gen_ready ? ST_TIMEOUT : r_st;
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gen   <= '0;
            r_ack   <= '0;
            r_dv    <= 1'b0;
            r_did   <= '0;
            r_dst   <= ST_OK;
            r_job   <= '0;
            r_st    <= ST_OK;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_gen   <= w_gen_nx;
            r_ack   <= w_ack_nx;
            r_dv    <= w_dv_nx;
            r_did   <= w_did_nx;
            r_dst   <= w_dst_nx;
            r_job   <= w_job_nx;
            r_st    <= w_st_nx;
        end
    end

    assign ack           = r_ack;
    assign done_valid    = r_dv;
    assign done_id       = r_did;
    assign done_status   = r_dst;
    assign gen_structure = r_gen;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_hamiltonian_scheduler.sv
// Directed bench for hamiltonian_scheduler: arbitration order, zero reject, timeouts, async reset.
module tb_hamiltonian_scheduler;

    localparam int N = 4;
    localparam int W = 256;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] structure_in = '0;
    logic           gen_ready = 1'b0;
    logic [N-1:0]   ack;
    logic           done_valid;
    logic [1:0]     done_id;
    logic [1:0]     done_status;
    logic [W-1:0]   gen_structure;
    logic           busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hamiltonian_scheduler #(.N_REQ(N), .STRUCT_W(W), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .structure_in  (structure_in),
        .ack           (ack),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .done_status   (done_status),
        .gen_structure (gen_structure),
        .gen_ready     (gen_ready),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int i);
        return W'(32'hC0DE_0010 + i);
    endfunction

    function automatic logic [W-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return W'(v);
    endfunction

    task automatic set_s(input int i, input logic [W-1:0] v);
        structure_in[i*W +: W] = v;
    endtask

    // Request idx is pending; run one nominal job and check its ack and completion.
    task automatic serve(input int idx);
        step();
        chk("serve_ack", W'(ack), oh(idx));
        chk("serve_gen", gen_structure, pat(idx));
        req[idx] = 1'b0;
        gen_ready = 1'b1;
        step();
        chk("serve_drain_gen", gen_structure, '0);
        gen_ready = 1'b0;
        step();
        chk("serve_done", W'({done_valid, done_status, done_id}), W'({1'b1, 2'b00, 2'(idx)}));
        chk("serve_idle", W'(busy), '0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_s(i, pat(i));
        step();
        step();
        chk("rst_ack", W'(ack), '0);
        chk("rst_done", W'({done_valid, done_status, done_id}), '0);
        chk("rst_gen", gen_structure, '0);
        chk("rst_busy", W'(busy), '0);
        reset = 1'b1;
        step();

        // Contention from rr_ptr=0, then 0 and 3 again
        req = 4'b1111;
        serve(0);
        serve(1);
        serve(2);
        serve(3);
        req = 4'b1001;
        serve(0);
        serve(3);

        // Single request with cycle-by-cycle timeline
        set_s(2, W'(8'hA5));
        req = 4'b0100;
        step();
        chk("single_ack", W'(ack), oh(2));
        chk("single_gen", gen_structure, W'(8'hA5));
        chk("single_busy", W'(busy), W'(1'b1));
        req = '0;
        set_s(2, pat(7));
        step();
        chk("single_ack_pulse", W'(ack), '0);
        chk("single_latched", gen_structure, W'(8'hA5));
        gen_ready = 1'b1;
        step();
        chk("single_drain_gen", gen_structure, '0);
        chk("single_drain_busy", W'(busy), W'(1'b1));
        step();
        chk("single_no_early_done", W'(done_valid), '0);
        gen_ready = 1'b0;
        step();
        chk("single_done", W'({done_valid, done_status, done_id}), W'({1'b1, 2'b00, 2'd2}));
        chk("single_idle", W'(busy), '0);
        step();
        chk("single_done_pulse", W'(done_valid), '0);
        chk("single_gen_after", gen_structure, '0);
        set_s(2, pat(2));

        // Zero structure: rr_ptr=3, so requester 1 wins after wrap
        set_s(1, '0);
        req = 4'b0010;
        step();
        chk("zero_ack", W'(ack), oh(1));
        chk("zero_done", W'({done_valid, done_status, done_id}), W'({1'b1, 2'b10, 2'd1}));
        chk("zero_busy", W'(busy), '0);
        chk("zero_gen", gen_structure, '0);
        req = '0;
        set_s(1, pat(1));
        step();
        chk("zero_after", W'({ack, done_valid, busy}), '0);

        // Stuck-low generator: rr_ptr=2, requester 0 wins after wrap
        req = 4'b0001;
        step();
        chk("tlow_ack", W'(ack), oh(0));
        req = '0;
        for (int k = 0; k < T - 1; k++) step();
        chk("tlow_still_wait", gen_structure, pat(0));
        chk("tlow_no_done", W'(done_valid), '0);
        step();
        chk("tlow_drain_gen", gen_structure, '0);
        chk("tlow_drain_busy", W'(busy), W'(1'b1));
        step();
        chk("tlow_done", W'({done_valid, done_status, done_id}), W'({1'b1, 2'b01, 2'd0}));
        req = 4'b0010;
        serve(1);

        // Stuck-high ready during DRAIN
        req = 4'b0100;
        step();
        chk("thigh_ack", W'(ack), oh(2));
        req = '0;
        gen_ready = 1'b1;
        step();
        chk("thigh_drain", gen_structure, '0);
        for (int k = 0; k < T - 1; k++) step();
        chk("thigh_no_done", W'(done_valid), '0);
        step();
        chk("thigh_done", W'({done_valid, done_status, done_id}), W'({1'b1, 2'b01, 2'd2}));
        chk("thigh_idle", W'(busy), '0);
        req = 4'b1000;
        step();
        step();
        step();
        chk("thigh_stall_ack", W'(ack), '0);
        chk("thigh_stall_busy", W'(busy), '0);
        gen_ready = 1'b0;
        serve(3);

        // Async reset in WAIT, then grant restarts from rr_ptr=0
        req = 4'b0010;
        step();
        chk("rstw_ack", W'(ack), oh(1));
        req = '0;
        step();
        chk("rstw_busy_pre", W'(busy), W'(1'b1));
        #2 reset = 1'b0;
        #1;
        chk("rstw_gen", gen_structure, '0);
        chk("rstw_busy", W'(busy), '0);
        chk("rstw_outs", W'({ack, done_valid, done_status, done_id}), '0);
        req = 4'b1001;
        step();
        chk("rstw_hold", W'({ack, busy}), '0);
        reset = 1'b1;
        serve(0);
        req = '0;
        step();
        chk("final_idle", W'({ack, done_valid, busy}), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
